// File: rtl/instr_mem_if.sv
// Fetch/response bus between the fetch unit and the instruction-memory responder,
// including the program-load write port used at boot and in test.
interface instr_mem_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        stall;
  logic        flush;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_addr, stall, flush, prog_we, prog_addr, prog_data,
    input  rsp_valid, rsp_addr, rsp_instr, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, stall, flush, prog_we, prog_addr, prog_data,
    output rsp_valid, rsp_addr, rsp_instr, rsp_err, busy
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word-addressed store read at acceptance, then a
// LATENCY-deep stall/flush-aware pipeline whose last stage drives the response.
module instr_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst,
  instr_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  err;
    logic [31:0] data;
  } stage_t;

  logic [31:0] mem [DEPTH];
  stage_t      pipe [LATENCY];

  logic [1:0]    req_err;
  logic [AW-1:0] req_idx;
  logic [31:0]   rd_word;
  logic [AW-1:0] prog_idx;
  logic          prog_in_range;
  logic          busy_any;
  logic          unused_prog_lsb;

  // bit1: word index beyond the store (no wrap); bit0: not word aligned
  assign req_err  = {bus.req_addr[31:2] >= 30'(DEPTH), bus.req_addr[1:0] != 2'b00};
  assign req_idx  = bus.req_addr[AW+1:2];
  assign rd_word  = (req_err != 2'b00) ? NOP_INSTR : mem[req_idx];

  assign prog_idx        = bus.prog_addr[AW+1:2];
  assign prog_in_range   = bus.prog_addr[31:2] < 30'(DEPTH);
  assign unused_prog_lsb = ^bus.prog_addr[1:0];

  // NOTE: the store itself is never reset; only its write enable is qualified by rst.
  always_ff @(posedge clk) begin
    if (!rst && bus.prog_we && prog_in_range) begin
      mem[prog_idx] <= bus.prog_data;
    end
  end

  // NOTE: non-blocking assignments make every stage sample its predecessor's pre-edge value,
  // which is also what gives read-first behaviour against a same-cycle program write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else if (bus.stall) begin
      if (bus.flush) begin
        for (int i = 0; i < LATENCY; i++) begin
          pipe[i].valid <= 1'b0;
        end
      end
    end else begin
      // Stage 1 takes the request even on flush: it is the redirect target.
      pipe[0] <= {bus.req_valid, bus.req_addr, req_err, rd_word};
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i]       <= pipe[i-1];
        pipe[i].valid <= pipe[i-1].valid & ~bus.flush;
      end
    end
  end

  // NOTE: default assigned first so the OR-reduction can never infer a latch.
  always_comb begin
    busy_any = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy_any = busy_any | pipe[i].valid;
    end
  end

  assign bus.rsp_valid = pipe[LATENCY-1].valid;
  assign bus.rsp_addr  = pipe[LATENCY-1].addr;
  assign bus.rsp_err   = pipe[LATENCY-1].err;
  assign bus.rsp_instr = pipe[LATENCY-1].data;
  assign bus.busy      = busy_any;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed vector table for the corner scenarios,
// then random traffic against an in-flight-list reference model.
module tb_instr_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          LAT   = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_if bus();

  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] addr;
    logic        stall;
    logic        flush;
    logic        we;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        ev;
    logic [31:0] eaddr;
    logic [31:0] einstr;
    logic [1:0]  eerr;
    logic        ebusy;
    logic        chk;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  err;
    logic [31:0] instr;
    int          age;
  } fl_t;

  vec_t        tbl[$];
  fl_t         fl[$];
  logic [31:0] mm [DEPTH];
  bit          m_zero;
  int          tests = 0;
  int          fails = 0;

  function automatic vec_t mk(int r, int rv, logic [31:0] a, int st, int f, int we,
                              logic [31:0] pa, logic [31:0] pd, int ev, logic [31:0] ea,
                              logic [31:0] ei, int ee, int eb, int chk);
    vec_t v;
    v.rst = (r != 0);  v.rv = (rv != 0);  v.addr = a;  v.stall = (st != 0);
    v.flush = (f != 0); v.we = (we != 0); v.paddr = pa; v.pdata = pd;
    v.ev = (ev != 0);  v.eaddr = ea;  v.einstr = ei;  v.eerr = 2'(ee);
    v.ebusy = (eb != 0); v.chk = (chk != 0);
    return v;
  endfunction

  function automatic logic [1:0] err_of(logic [31:0] a);
    return {((a >> 2) >= 32'(DEPTH)), ((a % 4) != 0)};
  endfunction

  // Reference: each accepted fetch ages by one per non-stalled edge and is
  // visible while its age equals LAT; flush or reset empties the list.
  task automatic model_edge(vec_t v);
    fl_t n;
    int  idx;
    if (v.rst) begin
      fl.delete();
      m_zero = 1'b1;
      return;
    end
    m_zero = 1'b0;
    if (!v.stall) begin
      foreach (fl[i]) fl[i].age++;
      while (fl.size() > 0 && fl[0].age > LAT) void'(fl.pop_front());
      if (v.flush) fl.delete();
      if (v.rv) begin
        n.addr  = v.addr;
        n.err   = err_of(v.addr);
        idx     = int'(v.addr >> 2);
        n.instr = (n.err != 2'b00) ? NOP : mm[idx];
        n.age   = 1;
        fl.push_back(n);
      end
    end else if (v.flush) begin
      fl.delete();
    end
    if (v.we && (v.paddr >> 2) < 32'(DEPTH)) begin
      idx = int'(v.paddr >> 2);
      mm[idx] = v.pdata;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    rst           = v.rst;
    bus.req_valid = v.rv;
    bus.req_addr  = v.addr;
    bus.stall     = v.stall;
    bus.flush     = v.flush;
    bus.prog_we   = v.we;
    bus.prog_addr = v.paddr;
    bus.prog_data = v.pdata;
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic check_vec(int k, vec_t v);
    check($sformatf("vec%0d rsp_valid", k), 32'(bus.rsp_valid), 32'(v.ev));
    check($sformatf("vec%0d busy", k), 32'(bus.busy), 32'(v.ebusy));
    if (v.chk) begin
      check($sformatf("vec%0d rsp_addr", k), bus.rsp_addr, v.eaddr);
      check($sformatf("vec%0d rsp_instr", k), bus.rsp_instr, v.einstr);
      check($sformatf("vec%0d rsp_err", k), 32'(bus.rsp_err), 32'(v.eerr));
    end
  endtask

  task automatic check_model(string tag);
    logic exp_valid;
    exp_valid = (fl.size() > 0) && (fl[0].age == LAT);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_valid));
    check({tag, " busy"}, 32'(bus.busy), 32'(fl.size() > 0));
    if (exp_valid) begin
      check({tag, " rsp_addr"}, bus.rsp_addr, fl[0].addr);
      check({tag, " rsp_instr"}, bus.rsp_instr, fl[0].instr);
      check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(fl[0].err));
    end else if (m_zero) begin
      check({tag, " rsp_addr zero"}, bus.rsp_addr, 32'h0);
      check({tag, " rsp_instr zero"}, bus.rsp_instr, 32'h0);
      check({tag, " rsp_err zero"}, 32'(bus.rsp_err), 32'h0);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return 32'hFFFF_FFFC;
      1:       return 32'($urandom_range(0, DEPTH * 4 + 16));
      default: return 32'($urandom_range(0, DEPTH - 1)) * 4;
    endcase
  endfunction

  initial begin
    vec_t        v;
    logic [31:0] w;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check_model($sformatf("reset%0d", i));
    end

    // Program load
    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0:       w = 32'h0050_0093;
        1:       w = 32'h00A0_0113;
        16:      w = 32'h0000_0063;
        default: w = 32'h1000_0000 + 32'(i);
      endcase
      apply(mk(0, 0, 0, 0, 0, 1, 32'(i) * 4, w, 0, 0, 0, 0, 0, 0));
    end

    // Back-to-back fetches
    tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h00A0_0113, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Stall while in stage 1, then while presenting
    tbl.push_back(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h00A0_0113, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, 0, 1, 1));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0, 1, 32'h4, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Flush with redirect target
    tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, 0, 1, 1));
    tbl.push_back(mk(0, 1, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h40, 32'h0000_0063, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Flush together with stall: cleared, nothing accepted
    tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, 0, 1, 1));
    tbl.push_back(mk(0, 1, 32'h8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Error responses and an out-of-range program write
    tbl.push_back(mk(0, 1, 32'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h2, NOP, 1, 1, 1));
    tbl.push_back(mk(0, 1, 32'h101, 0, 0, 0, 0, 0, 1, 32'h100, NOP, 2, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 32'h100, 32'hFFFF_FFFF, 1, 32'h101, NOP, 3, 1, 1));
    tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, 0, 1, 1));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, NOP, 2, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Reset with fetches in flight; request and program write during reset are dropped
    tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, 0, 1, 1));
    tbl.push_back(mk(1, 1, 32'h8, 0, 0, 1, 32'h8, 32'h0000_0BAD, 0, 32'h0, 32'h0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 0, 1, 32'h8, 32'h1000_0002, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Read-during-write returns the old word
    tbl.push_back(mk(0, 1, 32'h4, 0, 0, 1, 32'h4, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h4, 32'h00A0_0113, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h4, 32'hDEAD_BEEF, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      apply(tbl[k]);
      check_vec(k, tbl[k]);
    end

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      v = mk(($urandom_range(0, 39) == 0) ? 1 : 0,
             ($urandom_range(0, 3) != 0) ? 1 : 0, rnd_addr(),
             ($urandom_range(0, 4) == 0) ? 1 : 0,
             ($urandom_range(0, 7) == 0) ? 1 : 0,
             ($urandom_range(0, 3) == 0) ? 1 : 0, rnd_addr(), $urandom(),
             0, 0, 0, 0, 0, 0);
      apply(v);
      check_model($sformatf("rnd%0d", c));
    end

    // Sweep the whole store plus the first out-of-range words
    for (int i = 0; i < DEPTH + 4 + LAT; i++) begin
      apply(mk(0, (i < DEPTH + 4) ? 1 : 0, 32'(i) * 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check_model($sformatf("sweep%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
